// File: rtl/ahb_lite_cmd_initiator.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one AHB SINGLE
// transfer, and its data/status comes back on a valid/ready response channel.
module ahb_lite_cmd_initiator #(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_size,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   typedef enum logic [2:0] {StIdle, StAddr, StData, StErr2, StResp} state_e;

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;

   state_e            state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [31:0]       hwdata_q, hwdata_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              cmd_ok;
   logic [31:0]       rd_lane;
   logic [31:0]       wr_lanes;

   always_comb begin
      case (cmd_size)
         2'd0:    cmd_ok = 1'b1;
         2'd1:    cmd_ok = ~cmd_addr[0];
         2'd2:    cmd_ok = (cmd_addr[1:0] == 2'b00);
         default: cmd_ok = 1'b0;
      endcase
   end

   // Pick the addressed lane out of HRDATA and right-align it.
   always_comb begin
      case (hsize_q[1:0])
         2'd0:    rd_lane = {24'h0, HRDATA[{haddr_q[1:0], 3'b000} +: 8]};
         2'd1:    rd_lane = {16'h0, HRDATA[{haddr_q[1], 4'b0000} +: 16]};
         default: rd_lane = HRDATA;
      endcase
   end

   always_comb begin
      case (hsize_q[1:0])
         2'd0:    wr_lanes = {4{wdata_q[7:0]}};
         2'd1:    wr_lanes = {2{wdata_q[15:0]}};
         default: wr_lanes = wdata_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hwdata_d    = hwdata_q;
      wdata_d     = wdata_q;
      unique case (state_q)
         StIdle: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               if (cmd_ok) begin
                  haddr_d  = cmd_addr;
                  hwrite_d = cmd_write;
                  hsize_d  = {1'b0, cmd_size};
                  wdata_d  = cmd_wdata;
                  htrans_d = TransNonseq;
                  state_d  = StAddr;
               end else begin
                  // Alignment fault: answer directly, never touch the bus.
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
                  state_d     = StResp;
               end
            end
         end
         StAddr: begin
            if (HREADY) begin
               htrans_d = TransIdle;
               hwdata_d = wr_lanes;
               state_d  = StData;
            end
         end
         StData: begin
            if (HREADY) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = HRESP;
               rsp_rdata_d = (hwrite_q || HRESP) ? 32'h0 : rd_lane;
               state_d     = StResp;
            end else if (HRESP) begin
               state_d = StErr2;
            end
         end
         StErr2: begin
            if (HREADY) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'h0;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         htrans_q    <= TransIdle;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b000;
         hwdata_q    <= 32'h0;
         wdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign HTRANS    = htrans_q;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HWDATA    = hwdata_q;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_initiator.sv
// Directed bench for ahb_lite_cmd_initiator: the main thread plays command source and AHB slave,
// a monitor checks responses against a queue of expected {err, rdata}.
module tb_ahb_lite_cmd_initiator;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   ahb_lite_cmd_initiator #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   int          n_vec  = 0;
   int          n_miss = 0;
   int          nonseq_cnt = 0;
   int          ns_snap;
   logic        prev_nonseq = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] exp_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive phase: just after the rising edge. Sample phase: falling edge.
   task automatic cyc;
      @(posedge HCLK);
      #1;
   endtask

   task automatic smp;
      @(negedge HCLK);
   endtask

   task automatic send(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_size  = sz;
      cmd_addr  = a;
      cmd_wdata = d;
      cyc;
      cmd_valid = 1'b0;
   endtask

   // Legal transfer with aw address-phase wait states and zero-wait data phase.
   task automatic xfer(input string nm, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] hr,
                       input int aw, input logic [31:0] exp_hwdata, input logic [31:0] exp_rd);
      send(w, sz, a, d);
      exp_q.push_back({1'b0, exp_rd});
      for (int i = 0; i < aw; i++) begin
         HREADY = 1'b0;
         smp;
         chk({nm, " addr-wait htrans"}, {30'h0, HTRANS}, 32'h2);
         chk({nm, " addr-wait haddr"}, HADDR, a);
         cyc;
      end
      HREADY = 1'b1;
      smp;
      chk({nm, " nonseq"}, {30'h0, HTRANS}, 32'h2);
      chk({nm, " haddr"}, HADDR, a);
      chk({nm, " hsize"}, {29'h0, HSIZE}, {30'h0, sz});
      chk({nm, " hwrite"}, {31'h0, HWRITE}, {31'h0, w});
      cyc;
      HRDATA = hr;
      smp;
      chk({nm, " data-phase htrans"}, {30'h0, HTRANS}, 32'h0);
      if (w) chk({nm, " hwdata"}, HWDATA, exp_hwdata);
      chk({nm, " rsp_valid early"}, {31'h0, rsp_valid}, 32'h0);
      cyc;
      HRDATA = 32'h0;
      smp;
      chk({nm, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
      cyc;
   endtask

   // Response scoreboard.
   always @(negedge HCLK) begin
      if (!HRESET && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rsp_unexpected: got rdata %h err %b expected no response",
                     rsp_rdata, rsp_err);
         end else begin
            exp_e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, exp_e[31:0]);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_e[32]});
         end
      end
   end

   // Bus invariants: only IDLE/NONSEQ, NONSEQ address aligned to size.
   always @(negedge HCLK) begin
      if (!HRESET) begin
         if (HTRANS == 2'b01 || HTRANS == 2'b11) chk("htrans legal", {30'h0, HTRANS}, 32'h0);
         if (HTRANS == 2'b10) begin
            if (!prev_nonseq) nonseq_cnt++;
            if (HSIZE == 3'd1) chk("nonseq align hw", {31'h0, HADDR[0]}, 32'h0);
            if (HSIZE == 3'd2) chk("nonseq align w", {30'h0, HADDR[1:0]}, 32'h0);
         end
         prev_nonseq = (HTRANS == 2'b10);
      end else begin
         prev_nonseq = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
      cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b1;
      HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
      cyc; cyc; cyc;
      smp;
      chk("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("reset rsp_err", {31'h0, rsp_err}, 32'h0);
      chk("reset rsp_rdata", rsp_rdata, 32'h0);
      chk("reset htrans", {30'h0, HTRANS}, 32'h0);
      chk("reset haddr", HADDR, 32'h0);
      chk("reset hwdata", HWDATA, 32'h0);
      chk("reset hsize", {29'h0, HSIZE}, 32'h0);
      chk("const hburst/hprot/hmastlock", {24'h0, HBURST, HPROT, HMASTLOCK}, 32'h06);
      cyc;
      HRESET = 1'b0;

      // Word write, zero-wait.
      xfer("word write", 1'b1, 2'd2, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0, 0,
           32'hDEAD_BEEF, 32'h0);
      smp;
      chk("after hs cmd_ready", {31'h0, cmd_ready}, 32'h1);
      cyc;

      // Byte read lane 3 with two data-phase wait states: response at N+5.
      send(1'b0, 2'd0, 32'h2000_0013, 32'h0);
      exp_q.push_back({1'b0, 32'h0000_00A5});
      smp;
      chk("bread nonseq", {30'h0, HTRANS}, 32'h2);
      cyc;
      HREADY = 1'b0;
      smp;
      chk("bread wait haddr", HADDR, 32'h2000_0013);
      chk("bread wait hsize", {29'h0, HSIZE}, 32'h0);
      chk("bread wait htrans", {30'h0, HTRANS}, 32'h0);
      cyc;
      smp;
      chk("bread wait2 rsp_valid", {31'h0, rsp_valid}, 32'h0);
      cyc;
      HREADY = 1'b1;
      HRDATA = 32'hA511_2233;
      smp;
      chk("bread N+4 rsp_valid", {31'h0, rsp_valid}, 32'h0);
      cyc;
      HRDATA = 32'h0;
      smp;
      chk("bread N+5 rsp_valid", {31'h0, rsp_valid}, 32'h1);
      cyc;

      xfer("byte write", 1'b1, 2'd0, 32'h2000_0001, 32'h0000_007E, 32'h0, 0,
           32'h7E7E_7E7E, 32'h0);
      xfer("hw write", 1'b1, 2'd1, 32'h2000_0002, 32'hFFFF_1234, 32'h0, 0,
           32'h1234_1234, 32'h0);
      xfer("hw read", 1'b0, 2'd1, 32'h2000_0002, 32'h0, 32'hA511_2233, 1,
           32'h0, 32'h0000_A511);
      xfer("byte read lane1", 1'b0, 2'd0, 32'h2000_0001, 32'h0, 32'hA511_2233, 0,
           32'h0, 32'h0000_0022);
      xfer("word read", 1'b0, 2'd2, 32'h2000_0010, 32'h0, 32'hCAFE_F00D, 2,
           32'h0, 32'hCAFE_F00D);

      // Alignment faults: no bus activity, error response next cycle.
      ns_snap = nonseq_cnt;
      send(1'b0, 2'd1, 32'h2000_0003, 32'h0);
      exp_q.push_back({1'b1, 32'h0});
      smp;
      chk("misaligned hw rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("misaligned hw htrans", {30'h0, HTRANS}, 32'h0);
      cyc;
      send(1'b1, 2'd3, 32'h2000_0000, 32'h1111_1111);
      exp_q.push_back({1'b1, 32'h0});
      smp;
      chk("size3 rsp_valid", {31'h0, rsp_valid}, 32'h1);
      cyc;
      send(1'b0, 2'd2, 32'h2000_0006, 32'h0);
      exp_q.push_back({1'b1, 32'h0});
      smp;
      chk("misaligned w rsp_valid", {31'h0, rsp_valid}, 32'h1);
      cyc;
      chk("faults no nonseq", nonseq_cnt, ns_snap);

      // Two-cycle ERROR from default slave.
      send(1'b0, 2'd2, 32'h3000_0000, 32'h0);
      exp_q.push_back({1'b1, 32'h0});
      smp;
      chk("err nonseq", {30'h0, HTRANS}, 32'h2);
      cyc;
      HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hFFFF_FFFF;
      smp;
      chk("err cycle1 htrans", {30'h0, HTRANS}, 32'h0);
      cyc;
      HREADY = 1'b1; HRESP = 1'b1;
      smp;
      chk("err cycle2 htrans", {30'h0, HTRANS}, 32'h0);
      chk("err cycle2 rsp_valid", {31'h0, rsp_valid}, 32'h0);
      cyc;
      HRESP = 1'b0; HRDATA = 32'h0;
      smp;
      chk("err rsp_valid", {31'h0, rsp_valid}, 32'h1);
      cyc;

      // Response backpressure with a second command waiting.
      rsp_ready = 1'b0;
      send(1'b0, 2'd2, 32'h2000_0020, 32'h0);
      exp_q.push_back({1'b0, 32'h1357_9BDF});
      cyc;
      HRDATA = 32'h1357_9BDF;
      cyc;
      HRDATA = 32'h0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'd2;
      cmd_addr = 32'h2000_0024; cmd_wdata = 32'h0102_0304;
      ns_snap = nonseq_cnt;
      for (int i = 0; i < 4; i++) begin
         smp;
         chk("stall rsp_valid", {31'h0, rsp_valid}, 32'h1);
         chk("stall rsp_rdata", rsp_rdata, 32'h1357_9BDF);
         chk("stall cmd_ready", {31'h0, cmd_ready}, 32'h0);
         cyc;
      end
      chk("stall no nonseq", nonseq_cnt, ns_snap);
      rsp_ready = 1'b1;
      smp;
      cyc;
      exp_q.push_back({1'b0, 32'h0});
      smp;
      chk("gap htrans idle", {30'h0, HTRANS}, 32'h0);
      chk("gap cmd_ready", {31'h0, cmd_ready}, 32'h1);
      cyc;
      cmd_valid = 1'b0;
      smp;
      chk("b2b nonseq", {30'h0, HTRANS}, 32'h2);
      chk("b2b haddr", HADDR, 32'h2000_0024);
      cyc;
      smp;
      chk("b2b hwdata", HWDATA, 32'h0102_0304);
      cyc;
      smp;
      chk("b2b rsp_valid", {31'h0, rsp_valid}, 32'h1);
      cyc;

      // Reset during a stalled data phase discards the transfer.
      send(1'b0, 2'd2, 32'h2000_0040, 32'h0);
      cyc;
      HREADY = 1'b0;
      cyc;
      HRESET = 1'b1;
      cyc;
      HRESET = 1'b0; HREADY = 1'b1;
      smp;
      chk("rst htrans", {30'h0, HTRANS}, 32'h0);
      chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst haddr", HADDR, 32'h0);
      cyc;
      xfer("post-reset read", 1'b0, 2'd2, 32'h2000_0044, 32'h0, 32'h89AB_CDEF, 0,
           32'h0, 32'h89AB_CDEF);

      cyc; cyc;
      chk("scoreboard drained", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
